// File: rtl/input_capture_unit.sv
// Input-instruction capture: stalls the CPU until a debounced Enter press,
// then latches the synchronised, extended switch value for one write-back cycle.
module input_capture_unit #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SIGN_EXTEND     = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                key_enter_n,
  input  logic                input_request,
  output logic [31:0]         data_input,
  output logic                input_wait,
  output logic                input_done
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          key_sync;
  logic [SW_WIDTH-1:0] sw_meta, sw_sync;
  logic                deb_n;
  logic [CW-1:0]       cnt;
  logic                differ, flip, press_edge, capture;
  logic [31:0]         sw_ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_sync <= 2'b11;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_sync <= {key_sync[0], key_enter_n};
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
    end
  end

  // flip fires on the cycle the run of differing samples reaches its length
  assign differ     = key_sync[1] != deb_n;
  assign flip       = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press_edge = flip && deb_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_n <= 1'b1;
      cnt   <= '0;
    end else if (!differ) begin
      cnt   <= '0;
    end else if (flip) begin
      deb_n <= ~deb_n;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  generate
    if (SW_WIDTH == 32) begin : g_pass
      assign sw_ext = sw_sync;
    end else if (SIGN_EXTEND != 0) begin : g_sext
      assign sw_ext = {{(32-SW_WIDTH){sw_sync[SW_WIDTH-1]}}, sw_sync};
    end else begin : g_zext
      assign sw_ext = {{(32-SW_WIDTH){1'b0}}, sw_sync};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // IDLE judges the current debounced level, so a press edge landing in the
  // same cycle as the request is not a capture
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE:    if (input_request) state_d = deb_n ? S_ARMED : S_RELEASE;
      S_ARMED:   if (!input_request) state_d = S_IDLE;
                 else if (press_edge) begin
                   capture = 1'b1;
                   state_d = S_DONE;
                 end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (deb_n) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       data_input <= '0;
    else if (capture) data_input <= sw_ext;
  end

  assign input_done = (state_q == S_DONE);
  assign input_wait = input_request && (state_q != S_DONE);

endmodule

// File: tb/tb_input_capture_unit.sv
// Directed bench for input_capture_unit: zero- and sign-extending instances
// share stimulus and are checked every cycle against a window-based model.
module tb_input_capture_unit;
  localparam int SW = 16;
  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] switches = '0;
  logic        key_enter_n = 1'b1;
  logic        input_request = 1'b0;
  logic [31:0] data0, data1;
  logic        wait0, wait1, done0, done1;

  always #5 clock = ~clock;

  input_capture_unit #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(DC), .SIGN_EXTEND(0)) dut0 (
    .clock(clock), .reset(reset), .switches(switches), .key_enter_n(key_enter_n),
    .input_request(input_request), .data_input(data0), .input_wait(wait0),
    .input_done(done0));

  input_capture_unit #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(DC), .SIGN_EXTEND(1)) dut1 (
    .clock(clock), .reset(reset), .switches(switches), .key_enter_n(key_enter_n),
    .input_request(input_request), .data_input(data1), .input_wait(wait1),
    .input_done(done1));

  int errors = 0;
  int checks = 0;
  int ndone  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: raw samples are kept per clock edge. The debounced level flips at
  // edge k when the DC synchronised samples ending at k all differ from it and
  // none of them predates the previous flip (or reset).
  typedef enum {M_IDLE, M_ARMED, M_DONE, M_REL} mph_t;
  bit          rawk [0:8191];
  logic [15:0] raws [0:8191];
  int          cyc = 0, rlast = 0, last_flip = 0;
  bit          mdeb = 1'b1;
  mph_t        mph = M_IDLE;
  logic [31:0] mdata0 = '0, mdata1 = '0;

  function automatic bit ksync(int j);
    return (j - 2 > rlast) ? rawk[j-2] : 1'b1;
  endfunction

  task automatic model_step();
    bit flip, press;
    logic [15:0] sw;
    cyc++;
    rawk[cyc] = key_enter_n;
    raws[cyc] = switches;
    if (!reset) begin
      rlast = cyc; last_flip = cyc; mdeb = 1'b1; mph = M_IDLE;
      mdata0 = '0; mdata1 = '0;
      return;
    end
    flip = (cyc - last_flip >= DC);
    for (int j = cyc - DC + 1; j <= cyc; j++)
      if (ksync(j) == mdeb) flip = 1'b0;
    press = flip && mdeb;
    sw = (cyc - 2 > rlast) ? raws[cyc-2] : 16'h0;
    case (mph)
      M_IDLE:  if (input_request) mph = mdeb ? M_ARMED : M_REL;
      M_ARMED: if (!input_request) mph = M_IDLE;
               else if (press) begin
                 mdata0 = {16'h0, sw};
                 mdata1 = {{16{sw[15]}}, sw};
                 mph = M_DONE;
               end
      M_DONE:  mph = M_REL;
      M_REL:   if (mdeb) mph = M_IDLE;
    endcase
    if (flip) begin
      mdeb = ~mdeb;
      last_flip = cyc;
    end
  endtask

  always @(posedge clock) begin
    model_step();
    #2;
    chk("wait0", wait0, input_request && (mph != M_DONE));
    chk("wait1", wait1, input_request && (mph != M_DONE));
    chk("done0", done0, mph == M_DONE);
    chk("done1", done1, mph == M_DONE);
    chk("data0", data0, mdata0);
    chk("data1", data1, mdata1);
    if (done0) ndone++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // n = edges from press to input_done; 0 if it never arrives
  task automatic wait_done(input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clock); #2;
      if (done0) begin n = i; break; end
    end
  endtask

  task automatic capture(input logic [15:0] sw, input logic [31:0] e0,
                         input logic [31:0] e1, input string nm);
    int n;
    @(negedge clock);
    switches = sw; input_request = 1'b1;
    tick(3);
    key_enter_n = 1'b0;
    wait_done(20, n);
    chk({nm, "_latency"}, n, 6);
    chk({nm, "_data0"}, data0, e0);
    chk({nm, "_data1"}, data1, e1);
    tick(1);
    input_request = 1'b0;
    tick(4);
    key_enter_n = 1'b1;
    tick(12);
  endtask

  initial begin
    int n, d0;
    #1;
    chk("rst_data", data0, 32'h0);
    chk("rst_wait", wait0, 1'b0);
    chk("rst_done", done0, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(3);

    capture(16'h00A5, 32'h000000A5, 32'h000000A5, "basic");
    capture(16'h8001, 32'h00008001, 32'hFFFF8001, "sign");

    // bounce: runs of 2 never reach the 4-sample window
    d0 = ndone;
    input_request = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      key_enter_n = ~key_enter_n;
      tick(2);
    end
    tick(8);
    chk("bounce_done", ndone, d0);
    chk("bounce_wait", wait0, 1'b1);
    chk("bounce_data", data0, 32'h00008001);

    input_request = 1'b0;
    tick(2);
    chk("abandon_wait", wait0, 1'b0);

    // held key: re-request while pressed stalls until release and new press
    switches = 16'h0F0F; input_request = 1'b1;
    tick(3);
    key_enter_n = 1'b0;
    wait_done(20, n);
    chk("held_latency", n, 6);
    chk("held_data", data0, 32'h00000F0F);
    tick(1);
    input_request = 1'b0;
    tick(3);
    input_request = 1'b1;
    d0 = ndone;
    tick(12);
    chk("held_nodone", ndone, d0);
    chk("held_wait", wait0, 1'b1);
    key_enter_n = 1'b1; switches = 16'h0A0A;
    tick(10);
    key_enter_n = 1'b0;
    wait_done(20, n);
    chk("held2_latency", n, 6);
    tick(1);
    chk("held2_count", ndone, d0 + 1);
    chk("held2_data", data0, 32'h00000A0A);
    input_request = 1'b0;
    tick(4);
    key_enter_n = 1'b1;
    tick(12);

    // request arrives on the very cycle of the press edge: no capture
    key_enter_n = 1'b0;
    tick(5);
    input_request = 1'b1;
    d0 = ndone;
    tick(10);
    chk("same_nodone", ndone, d0);
    chk("same_wait", wait0, 1'b1);
    key_enter_n = 1'b1;
    tick(10);
    switches = 16'h5A5A;
    key_enter_n = 1'b0;
    wait_done(20, n);
    chk("same2_latency", n, 6);
    chk("same2_data", data0, 32'h00005A5A);
    tick(1);
    input_request = 1'b0;
    tick(4);
    key_enter_n = 1'b1;
    tick(12);

    capture(16'h1234, 32'h00001234, 32'h00001234, "b2b_a");
    capture(16'h00FF, 32'h000000FF, 32'h000000FF, "b2b_b");

    // reset mid-debounce
    input_request = 1'b1;
    tick(2);
    key_enter_n = 1'b0;
    tick(3);
    reset = 1'b0; input_request = 1'b0;
    #1;
    chk("mid_rst_data0", data0, 32'h0);
    chk("mid_rst_data1", data1, 32'h0);
    chk("mid_rst_wait", wait0, 1'b0);
    chk("mid_rst_done", done0, 1'b0);
    tick(2);
    key_enter_n = 1'b1; reset = 1'b1;
    tick(10);

    capture(16'hC3C3, 32'h0000C3C3, 32'hFFFFC3C3, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
